// File: rtl/wbu.sv
// wbu: write-back stage of the NPC core.
// Accepts one retiring instruction per handshake, waits for load data when
// needed, then issues a one-cycle register-file write and commit pulse.
// Optional load watchdog: define WBU_LOAD_TIMEOUT_EN to build it; without it
// WAIT_MEM waits indefinitely and mem_timeout is tied low.
//
// Handshake: a transfer happens on a rising edge where lsu_valid && wbu_ready.
// wbu_ready is high only in IDLE outside reset; lsu_valid held while
// wbu_ready=0 is the same pending instruction, not a new one.
module wbu #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  output logic        wbu_ready,
  input  logic [31:0] pc,
  input  logic [4:0]  rd,
  input  logic        reg_wen,
  input  logic        mem_ren,
  input  logic [31:0] exu_result,
  input  logic        sram_valid,
  input  logic [31:0] memory_read_wd,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic        mem_timeout,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] COMMIT   = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [4:0]  rd_q;
  logic        reg_wen_q;
  logic        accept;
  logic        timeout_hit;

  // Ready is combinational from state so it is low during the reset cycle.
  assign wbu_ready = (state == IDLE) && !rst;
  assign accept    = lsu_valid && wbu_ready;
  assign state_dbg = state;

`ifdef WBU_LOAD_TIMEOUT_EN
  // Last wait cycle before the counter would reach all-ones (2^W-2 counted).
  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = ~TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 timeout_q;

  // sram_valid on the limit cycle wins, so the hit requires it to be low.
  assign timeout_hit = (state == WAIT_MEM) && !sram_valid && (wait_cnt == LAST_WAIT);
  assign mem_timeout = timeout_q;

  // Watchdog: counts WAIT_MEM cycles without load data; the error flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt <= '0;
      end else if ((state == WAIT_MEM) && !sram_valid) begin
        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  // Stage FSM plus registered write-back/commit outputs, loaded on entry to COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc_q         <= '0;
      rd_q         <= '0;
      reg_wen_q    <= 1'b0;
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
    end else begin
      rf_wen       <= 1'b0;
      commit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pc_q      <= pc;
            rd_q      <= rd;
            reg_wen_q <= reg_wen;
            if (mem_ren) begin
              state <= WAIT_MEM;
            end else begin
              state        <= COMMIT;
              commit_valid <= 1'b1;
              commit_pc    <= pc;
              rf_waddr     <= rd;
              rf_wdata     <= exu_result;
              rf_wen       <= reg_wen && (rd != 5'd0);
            end
          end
        end
        WAIT_MEM: begin
          if (sram_valid) begin
            state        <= COMMIT;
            commit_valid <= 1'b1;
            commit_pc    <= pc_q;
            rf_waddr     <= rd_q;
            rf_wdata     <= memory_read_wd;
            rf_wen       <= reg_wen_q && (rd_q != 5'd0);
          end else if (timeout_hit) begin
            // Retire without writing so the core keeps running.
            state        <= COMMIT;
            commit_valid <= 1'b1;
            commit_pc    <= pc_q;
            rf_waddr     <= rd_q;
            rf_wdata     <= '0;
            rf_wen       <= 1'b0;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
